ldm_stm_seq: RTL and testbench

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

---
 rtl/ldm_stm_seq_pkg.sv | 22 ++
 rtl/ldm_stm_seq_lsb_enc.sv | 20 ++
 rtl/ldm_stm_seq.sv | 195 +++++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_seq_pkg.sv
// rtl/ldm_stm_seq_pkg.sv - shared state type, stride constant and popcount helper
package ldm_stm_seq_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } seq_state_e;

  // Number of registers named in a transfer mask.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_lsb_enc.sv
// rtl/ldm_stm_seq_lsb_enc.sv - 16-bit lowest-set-bit encoder
module lsb_enc (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan from the top so the lowest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/ldm_stm_seq.sv
// rtl/ldm_stm_seq.sv - LDM/STM block transfer sequencer
module ldm_stm_seq
  import ldm_stm_seq_pkg::*;
#(
  parameter int unsigned WORD_BYTES = ldm_stm_seq_pkg::WORD_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic [15:0] reg_list,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_val,
  input  logic        up,
  input  logic        pre,
  input  logic        wback,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] str_data,
  output logic [3:0]  str_addr,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  output logic [3:0]  w_addr1,
  output logic [31:0] w_data1,
  output logic        w_en1,
  output logic [3:0]  w_addr2,
  output logic [31:0] w_data2,
  output logic        w_en2,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

  seq_state_e  state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] addr_q, addr_d;
  logic        is_load_q, is_load_d;
  logic [3:0]  base_reg_q, base_reg_d;
  logic        wb_en_q, wb_en_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic        ld_pend_q, ld_pend_d;
  logic [3:0]  ld_reg_q, ld_reg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        w_en2_q, w_en2_d;

  logic [3:0]  cur_idx;
  logic        cur_valid;
  logic [4:0]  n_w;
  logic [31:0] span_w;
  logic        wb_en_w;
  logic [15:0] rem_next_w;

  lsb_enc u_lsb_enc (
    .vec   (rem_q),
    .idx   (cur_idx),
    .valid (cur_valid)
  );

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    is_load_d  = is_load_q;
    base_reg_d = base_reg_q;
    wb_en_d    = wb_en_q;
    wb_val_d   = wb_val_q;
    ld_pend_d  = 1'b0;
    ld_reg_d   = ld_reg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = rd_en_q;
    wr_en_d    = wr_en_q;
    w_en2_d    = 1'b0;

    n_w        = popcount16(reg_list);
    span_w     = STRIDE * {27'd0, n_w};
    // A load that names the base register owns that register's final value.
    wb_en_w    = wback && !(is_load && reg_list[base_reg]);
    rem_next_w = rem_q & (rem_q - 16'd1);

    case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        if (start) begin
          is_load_d  = is_load;
          base_reg_d = base_reg;
          rem_d      = reg_list;
          wb_en_d    = wb_en_w;
          wb_val_d   = up ? (base_val + span_w) : (base_val - span_w);
          if (up) begin
            addr_d = pre ? (base_val + STRIDE) : base_val;
          end else begin
            addr_d = pre ? (base_val - span_w) : (base_val - span_w + STRIDE);
          end
          busy_d = 1'b1;
          if (n_w == 5'd0) begin
            state_d = FIN;
            done_d  = 1'b1;
            w_en2_d = wb_en_w;
          end else begin
            state_d = XFER;
            rd_en_d = is_load;
            wr_en_d = !is_load;
          end
        end
      end
      XFER: begin
        if (mem_ready && cur_valid) begin
          ld_pend_d = is_load_q;
          ld_reg_d  = cur_idx;
          rem_d     = rem_next_w;
          addr_d    = addr_q + STRIDE;
          if (rem_next_w == 16'd0) begin
            state_d = FIN;
            done_d  = 1'b1;
            w_en2_d = wb_en_q;
            rd_en_d = 1'b0;
            wr_en_d = 1'b0;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any pending load write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      addr_q     <= '0;
      is_load_q  <= 1'b0;
      base_reg_q <= '0;
      wb_en_q    <= 1'b0;
      wb_val_q   <= '0;
      ld_pend_q  <= 1'b0;
      ld_reg_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      w_en2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      is_load_q  <= is_load_d;
      base_reg_q <= base_reg_d;
      wb_en_q    <= wb_en_d;
      wb_val_q   <= wb_val_d;
      ld_pend_q  <= ld_pend_d;
      ld_reg_q   <= ld_reg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      w_en2_q    <= w_en2_d;
    end
  end

  assign str_addr  = cur_idx;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_wdata = str_data;
  assign w_addr1   = ld_reg_q;
  assign w_data1   = mem_rdata;
  assign w_en1     = ld_pend_q;
  assign w_addr2   = base_reg_q;
  assign w_data2   = wb_val_q;
  assign w_en2     = w_en2_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb/tb_ldm_stm_seq.sv - self-checking bench for ldm_stm_seq
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, up, pre, wback, mem_ready;
  logic [15:0] reg_list;
  logic [3:0]  base_reg;
  logic [31:0] base_val, mem_rdata, str_data;
  logic [3:0]  str_addr, w_addr1, w_addr2;
  logic [31:0] mem_addr, mem_wdata, w_data1, w_data2;
  logic        mem_rd_en, mem_wr_en, w_en1, w_en2, busy, done;

  always #5 clk = ~clk;

  ldm_stm_seq #(.WORD_BYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .reg_list(reg_list),
    .base_reg(base_reg), .base_val(base_val), .up(up), .pre(pre), .wback(wback),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .str_data(str_data),
    .str_addr(str_addr), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .w_addr1(w_addr1),
    .w_data1(w_data1), .w_en1(w_en1), .w_addr2(w_addr2), .w_data2(w_data2),
    .w_en2(w_en2), .busy(busy), .done(done)
  );

  // Register file read port: each register holds a recognisable value.
  assign str_data = 32'hC0DE_0000 | {28'd0, str_addr};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  // Memory: a read of address a returns a ^ 5A5A0000 on the next cycle.
  bit          acc_rd;
  logic [31:0] acc_addr;
  always @(negedge clk) begin
    acc_rd   = (mem_rd_en === 1'b1) && (mem_ready === 1'b1);
    acc_addr = mem_addr;
  end
  always @(posedge clk) begin
    #1;
    mem_rdata = acc_rd ? (acc_addr ^ 32'h5A5A_0000) : $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Observation logs of actual DUT behaviour for literal checks.
  logic [31:0] log_addr[$];
  int          log_sreg[$];
  int          log_w1reg[$];
  int          start_cyc;
  int          done_cyc;
  bit          w2_seen;
  logic [31:0] w2_val;
  bit          w1_with_done;

  // Behavioural model: the pending list of (register, address) requests.
  int          m_reg[$];
  logic [31:0] m_addr[$];
  bit          m_busy = 0, m_fin = 0, m_load = 0, m_wb = 0, m_pend = 0;
  int          m_preg;
  logic [31:0] m_paddr, m_wbval, lo;
  logic [3:0]  m_breg;
  bit          xfer_e, np;
  int          nn;

  always @(negedge clk) begin
    if (chk_en) begin
      xfer_e = m_busy && !m_fin && (m_reg.size() > 0);
      chk1("busy", busy, m_busy);
      chk1("done", done, m_fin);
      chk1("rd_en", mem_rd_en, xfer_e && m_load);
      chk1("wr_en", mem_wr_en, xfer_e && !m_load);
      chk1("w_en1", w_en1, m_pend);
      chk1("w_en2", w_en2, m_fin && m_wb);
      if (xfer_e) begin
        chk("mem_addr", mem_addr, m_addr[0]);
        if (!m_load) begin
          chk("str_addr", 32'(str_addr), 32'(m_reg[0]));
          chk("mem_wdata", mem_wdata, 32'hC0DE_0000 | 32'(m_reg[0]));
        end
      end
      if (m_pend) begin
        chk("w_addr1", 32'(w_addr1), 32'(m_preg));
        chk("w_data1", w_data1, m_paddr ^ 32'h5A5A_0000);
      end
      if (m_fin && m_wb) begin
        chk("w_addr2", 32'(w_addr2), 32'(m_breg));
        chk("w_data2", w_data2, m_wbval);
      end

      if ((mem_rd_en === 1'b1 || mem_wr_en === 1'b1) && mem_ready) begin
        log_addr.push_back(mem_addr);
        if (mem_wr_en === 1'b1) log_sreg.push_back(int'(str_addr));
      end
      if (w_en1 === 1'b1) log_w1reg.push_back(int'(w_addr1));
      if (done === 1'b1) begin
        done_cyc = cyc - start_cyc;
        if (w_en1 === 1'b1) w1_with_done = 1'b1;
      end
      if (w_en2 === 1'b1) begin
        w2_seen = 1'b1;
        w2_val  = w_data2;
      end

      if (rst) begin
        m_busy = 0; m_fin = 0; m_pend = 0;
        m_reg.delete(); m_addr.delete();
      end else begin
        np = 1'b0;
        if (m_fin) begin
          m_fin = 0; m_busy = 0;
        end else if (m_busy) begin
          if (mem_ready) begin
            np      = m_load;
            m_preg  = m_reg.pop_front();
            m_paddr = m_addr.pop_front();
            if (m_reg.size() == 0) m_fin = 1;
          end
        end else if (start) begin
          m_reg.delete(); m_addr.delete();
          nn = 0;
          for (int i = 0; i < 16; i++) begin
            if (reg_list[i]) begin
              m_reg.push_back(i);
              nn++;
            end
          end
          if (up) lo = pre ? base_val + 32'd4 : base_val;
          else    lo = pre ? base_val - 32'(4 * nn) : base_val - 32'(4 * nn) + 32'd4;
          for (int k = 0; k < nn; k++) m_addr.push_back(lo + 32'(4 * k));
          m_busy  = 1;
          m_fin   = (nn == 0);
          m_load  = is_load;
          m_breg  = base_reg;
          m_wb    = wback && !(is_load && reg_list[base_reg]);
          m_wbval = up ? base_val + 32'(4 * nn) : base_val - 32'(4 * nn);
        end
        m_pend = np;
      end
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_sreg.delete(); log_w1reg.delete();
    done_cyc = -1; w2_seen = 0; w2_val = '0; w1_with_done = 0;
  endtask

  task automatic run_op(input bit ld, input logic [15:0] rl, input logic [3:0] br,
                        input logic [31:0] bv, input bit u, input bit p, input bit w,
                        input int sf, input int sl, input bit rnd);
    int k;
    clear_logs();
    start = 1; is_load = ld; reg_list = rl; base_reg = br; base_val = bv;
    up = u; pre = p; wback = w; mem_ready = 1; start_cyc = cyc;
    k = 0;
    forever begin
      @(posedge clk); #1; k++;
      if (busy !== 1'b1) break;
      if (k > 400) begin
        tests++; fails++;
        $display("FAIL timeout: busy=%b after %0d cycles, expected 0", busy, k);
        break;
      end
      if (rnd) begin
        start = 1'($urandom_range(0, 1));
        reg_list = 16'($urandom); base_val = $urandom; base_reg = 4'($urandom);
        is_load = 1'($urandom); up = 1'($urandom); pre = 1'($urandom); wback = 1'($urandom);
        mem_ready = ($urandom_range(0, 3) != 0);
      end else begin
        start = 0;
        mem_ready = !(k >= sf && k < sf + sl);
      end
    end
    start = 0; mem_ready = 1;
  endtask

  initial begin
    rst = 1; start = 0; is_load = 0; reg_list = '0; base_reg = '0; base_val = '0;
    up = 0; pre = 0; wback = 0; mem_ready = 1;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_rd", mem_rd_en, 1'b0);
    chk1("rst_wr", mem_wr_en, 1'b0);
    chk1("rst_w1", w_en1, 1'b0);
    chk1("rst_w2", w_en2, 1'b0);
    @(posedge clk); #1;
    rst = 0;

    // STM IA
    run_op(0, 16'h0016, 4'd13, 32'h100, 1, 0, 1, 0, 0, 0);
    chk("ia_n", 32'(log_addr.size()), 32'd3);
    chk("ia_a0", log_addr[0], 32'h100);
    chk("ia_a1", log_addr[1], 32'h104);
    chk("ia_a2", log_addr[2], 32'h108);
    chk("ia_r0", 32'(log_sreg[0]), 32'd1);
    chk("ia_r1", 32'(log_sreg[1]), 32'd2);
    chk("ia_r2", 32'(log_sreg[2]), 32'd4);
    chk("ia_done", 32'(done_cyc), 32'd4);
    chk("ia_wb", w2_val, 32'h10C);

    // LDM DB with R15
    run_op(1, 16'h8003, 4'd5, 32'h200, 0, 1, 1, 0, 0, 0);
    chk("db_a0", log_addr[0], 32'h1F4);
    chk("db_a1", log_addr[1], 32'h1F8);
    chk("db_a2", log_addr[2], 32'h1FC);
    chk("db_r0", 32'(log_w1reg[0]), 32'd0);
    chk("db_r1", 32'(log_w1reg[1]), 32'd1);
    chk("db_r2", 32'(log_w1reg[2]), 32'd15);
    chk("db_done", 32'(done_cyc), 32'd4);
    chk("db_wb", w2_val, 32'h1F4);
    chk1("db_w1_with_done", w1_with_done, 1'b1);

    // LDM IA with base in list
    run_op(1, 16'h0004, 4'd2, 32'h400, 1, 0, 1, 0, 0, 0);
    chk1("bil_no_wb", w2_seen, 1'b0);
    chk("bil_nw1", 32'(log_w1reg.size()), 32'd1);
    chk("bil_r", 32'(log_w1reg[0]), 32'd2);

    // LDM DA
    run_op(1, 16'h0003, 4'd3, 32'h50, 0, 0, 1, 0, 0, 0);
    chk("da_a0", log_addr[0], 32'h4C);
    chk("da_a1", log_addr[1], 32'h50);
    chk("da_wb", w2_val, 32'h48);

    // Stall on the second request for two cycles
    run_op(0, 16'h0016, 4'd13, 32'h100, 1, 0, 1, 2, 2, 0);
    chk("st_n", 32'(log_addr.size()), 32'd3);
    chk("st_a1", log_addr[1], 32'h104);
    chk("st_done", 32'(done_cyc), 32'd6);

    // Empty list
    run_op(0, 16'h0000, 4'd7, 32'h300, 1, 1, 1, 0, 0, 0);
    chk("em_n", 32'(log_addr.size()), 32'd0);
    chk("em_done", 32'(done_cyc), 32'd1);
    chk1("em_w2", w2_seen, 1'b1);
    chk("em_wb", w2_val, 32'h300);

    // Reset in cycle 2 of an 8-register LDM
    clear_logs();
    start = 1; is_load = 1; reg_list = 16'h00FF; base_reg = 4'd9; base_val = 32'h1000;
    up = 1; pre = 0; wback = 1; mem_ready = 1; start_cyc = cyc;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    chk1("rs_busy", busy, 1'b0);
    chk1("rs_rd", mem_rd_en, 1'b0);
    chk1("rs_w1", w_en1, 1'b0);
    chk1("rs_w2", w_en2, 1'b0);
    chk1("rs_done", done, 1'b0);
    chk1("rs_no_wb", w2_seen, 1'b0);
    @(posedge clk); #1;
    run_op(1, 16'h00FF, 4'd9, 32'h1000, 1, 0, 1, 0, 0, 0);
    chk("rs_after_done", 32'(done_cyc), 32'd9);
    chk("rs_after_wb", w2_val, 32'h1020);

    // Randomized operations with random stalls and ignored starts while busy
    repeat (60) begin
      run_op(1'($urandom), ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
             4'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
